wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the two writeback/complete ports among NUM_REQ functional-unit result streams (ALU0, ALU1, MDU, LSU).
- Each requester gets a one-entry holding slot. A round-robin picker grants up to two occupied slots per cycle.
- Grants are registered onto wb port 0/1, which feed the regfile write, busytable wakeup and ROB completion logic of the commit stage.
- flush discards all in-flight results.

Parameters:
- NUM_REQ, 4, number of requesting functional units (2..8)
- DATA_W, 32, result width
- PREG_W, 6, physical register index width
- ROB_W, 4, ROB entry index width
- EXC_W, 5, exception code width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush from commit, synchronous
- req_valid  in  NUM_REQ  per-requester result valid
- req_ready  out  NUM_REQ  per-requester slot accept
- req_rob_idx  in  NUM_REQ*ROB_W  ROB entry number, requester i at slice i
- req_phy_dest  in  NUM_REQ*PREG_W  physical destination
- req_rf_we  in  NUM_REQ  register write enable
- req_result  in  NUM_REQ*DATA_W  result data
- req_ex  in  NUM_REQ  exception flag
- req_excode  in  NUM_REQ*EXC_W  exception code
- wb_valid  out  2  port valid (bit 0 = port 0)
- wb_rob_idx  out  2*ROB_W  per-port ROB index
- wb_phy_dest  out  2*PREG_W  per-port physical destination
- wb_rf_we  out  2  per-port write enable (already ANDed with wb_valid)
- wb_result  out  2*DATA_W  per-port data
- wb_ex  out  2  per-port exception flag
- wb_excode  out  2*EXC_W  per-port exception code

Behaviour:
- State:
  - slot_v[i] and slot payload[i] for each requester
  - rr_ptr, width clog2(NUM_REQ)
  - registered output ports
- Reset: slot_v=0, rr_ptr=0, wb_valid=0, all wb_* payload=0.
- Acceptance:
  - req_ready[i] = !flush && (!slot_v[i] || grant[i]). This is combinational and does not depend on req_valid.
  - On an edge with req_valid[i] && req_ready[i], the slot loads the payload and slot_v[i]=1.
  - If grant[i] && !accept[i], slot_v[i] clears.
- Arbitration (combinational, over slot_v only):
  - Scan indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - The first occupied slot is g0 and goes to port 0; the second occupied slot is g1 and goes to port 1.
  - At most 2 grants per cycle.
- Output:
  - On each edge, wb port k loads payload[gk], with wb_valid[k]=1 if gk exists, else wb_valid[k]=0.
  - wb_valid[1] is never 1 while wb_valid[0]=0.
- Latency:
  - Request accepted at edge E0 appears on wb outputs after edge E1 at the earliest (2 edges).
  - A requester held in its slot keeps stable slot contents until granted.
- Throughput:
  - One result per requester per cycle when continuously granted (ready stays high via grant).
  - Aggregate throughput is 2 per cycle.
- rr_ptr update:
  - If g1 granted, rr_ptr <= g1+1 mod NUM_REQ.
  - Else if only g0 granted, rr_ptr <= g0+1.
  - Else unchanged.
- Fairness: any occupied slot is granted within ceil(NUM_REQ/2) cycles.
- Flush (has priority over everything except reset):
  - On the flush edge: slot_v=0, wb_valid=0, new requests are not accepted (req_ready=0 while flush=1).
  - rr_ptr unchanged.
- Simultaneous grant+accept on the same slot: the new payload replaces the granted one; the granted one is already captured into the wb register.
- Arithmetic: all index arithmetic wraps modulo NUM_REQ. NUM_REQ that is not a power of two must wrap explicitly, not by truncation.

Decomposition:
- Package cpu_pkg: typedef wb_req_t {rob_idx, phy_dest, rf_we, result, ex, excode}. Ports are exposed flattened; pack and unpack internally.
- Sub-module rr_pick2: combinational, inputs req vector and ptr, outputs g0_v, g0_idx, g1_v, g1_idx. Unit-testable alone.

Test Plan:
- Reset -> wb_valid=00, req_ready=1111, rr_ptr=0. One cycle later, only requester 2 valid with rob_idx=5, result=0xDEADBEEF -> after 2 edges, wb_valid=01, port 0 rob_idx=5, result=0xDEADBEEF, wb_valid[1]=0.
- All 4 requesters valid every cycle, rr_ptr=0 -> grants (0,1), (2,3), (0,1) on successive cycles; req_ready toggles so that each requester completes one result per 2 cycles.
- Slots 1 and 3 occupied with rr_ptr=2 -> port 0 gets requester 3, port 1 gets requester 1; rr_ptr becomes 2.
- Requester 0 held (lost arbitration) while req_valid stays high -> req_ready[0]=0 until grant; payload is delivered unchanged.
- flush asserted with all slots full and wb_valid=11 -> next cycle wb_valid=00 and slot_v=0. Requests presented during the flush cycle never appear on wb outputs; rr_ptr is preserved.
- rf_we=0 with ex=1, excode=0x0C, on requester 3 alone -> wb_valid[0]=1, wb_rf_we[0]=0, wb_ex[0]=1, wb_excode=0x0C.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared payload type for the writeback port arbiter: one functional-unit result
// as carried through a holding slot and out onto a writeback port.
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_PREG_W = 6;
    localparam int CPU_ROB_W  = 4;
    localparam int CPU_EXC_W  = 5;

    typedef struct packed {
        logic [CPU_ROB_W-1:0]  rob_idx;
        logic [CPU_PREG_W-1:0] phy_dest;
        logic                  rf_we;
        logic [CPU_DATA_W-1:0] result;
        logic                  ex;
        logic [CPU_EXC_W-1:0]  excode;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the flattened requester inputs and writeback port outputs.
// slave = arbiter side, master = functional units plus commit-stage side.
interface wb_port_arbiter_if
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = CPU_DATA_W,
    parameter int PREG_W  = CPU_PREG_W,
    parameter int ROB_W   = CPU_ROB_W,
    parameter int EXC_W   = CPU_EXC_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ROB_W-1:0]  req_rob_idx;
    logic [NUM_REQ*PREG_W-1:0] req_phy_dest;
    logic [NUM_REQ-1:0]        req_rf_we;
    logic [NUM_REQ*DATA_W-1:0] req_result;
    logic [NUM_REQ-1:0]        req_ex;
    logic [NUM_REQ*EXC_W-1:0]  req_excode;

    logic [1:0]                wb_valid;
    logic [2*ROB_W-1:0]        wb_rob_idx;
    logic [2*PREG_W-1:0]       wb_phy_dest;
    logic [1:0]                wb_rf_we;
    logic [2*DATA_W-1:0]       wb_result;
    logic [1:0]                wb_ex;
    logic [2*EXC_W-1:0]        wb_excode;

    modport slave (
        input  req_valid, req_rob_idx, req_phy_dest, req_rf_we, req_result, req_ex, req_excode,
        output req_ready,
        output wb_valid, wb_rob_idx, wb_phy_dest, wb_rf_we, wb_result, wb_ex, wb_excode
    );

    modport master (
        output req_valid, req_rob_idx, req_phy_dest, req_rf_we, req_result, req_ex, req_excode,
        input  req_ready,
        input  wb_valid, wb_rob_idx, wb_phy_dest, wb_rf_we, wb_result, wb_ex, wb_excode
    );

endinterface

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Combinational round-robin picker: finds the first two set bits of i_req,
// scanning upward from i_ptr with wraparound at NUM_REQ.
module rr_pick2 #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic               o_g0_v,
    output logic [PTR_W-1:0]   o_g0_idx,
    output logic               o_g1_v,
    output logic [PTR_W-1:0]   o_g1_idx
);

    // One extra bit so ptr+k never overflows before the explicit modulo wrap.
    always_comb begin : p_scan
        logic [PTR_W:0]   w_sum;
        logic [PTR_W-1:0] w_idx;
        o_g0_v   = 1'b0;
        o_g0_idx = '0;
        o_g1_v   = 1'b0;
        o_g1_idx = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (i_req[w_idx]) begin
                if (!o_g0_v) begin
                    o_g0_v   = 1'b1;
                    o_g0_idx = w_idx;
                end else if (!o_g1_v) begin
                    o_g1_v   = 1'b1;
                    o_g1_idx = w_idx;
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares two writeback ports among NUM_REQ functional-unit result streams.
// Each requester owns a one-entry slot; up to two slots are granted per cycle.
module wb_port_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = CPU_DATA_W,
    parameter int PREG_W  = CPU_PREG_W,
    parameter int ROB_W   = CPU_ROB_W,
    parameter int EXC_W   = CPU_EXC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    wb_port_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    wb_req_t            w_reqIn [NUM_REQ];
    wb_req_t            r_slot  [NUM_REQ];
    logic [NUM_REQ-1:0] r_slotV;
    logic [PTR_W-1:0]   r_rrPtr;

    logic               w_g0V;
    logic               w_g1V;
    logic [PTR_W-1:0]   w_g0Idx;
    logic [PTR_W-1:0]   w_g1Idx;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_reqReady;
    logic [NUM_REQ-1:0] w_accept;

    logic [1:0]         r_wbValid;
    wb_req_t            r_wbPort [2];

    function automatic logic [PTR_W-1:0] nextIdx(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_reqIn[i] = '{
            rob_idx:  bus.req_rob_idx[i*ROB_W +: ROB_W],
            phy_dest: bus.req_phy_dest[i*PREG_W +: PREG_W],
            rf_we:    bus.req_rf_we[i],
            result:   bus.req_result[i*DATA_W +: DATA_W],
            ex:       bus.req_ex[i],
            excode:   bus.req_excode[i*EXC_W +: EXC_W]
        };
    end

    rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req    (r_slotV),
        .i_ptr    (r_rrPtr),
        .o_g0_v   (w_g0V),
        .o_g0_idx (w_g0Idx),
        .o_g1_v   (w_g1V),
        .o_g1_idx (w_g1Idx)
    );

    // A slot being granted this cycle can take a new result on the same edge.
    always_comb begin
        w_grant = '0;
        if (w_g0V) w_grant[w_g0Idx] = 1'b1;
        if (w_g1V) w_grant[w_g1Idx] = 1'b1;
        w_reqReady = flush ? '0 : (~r_slotV | w_grant);
        w_accept   = bus.req_valid & w_reqReady;
    end

    assign bus.req_ready = w_reqReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slotV <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_slot[i] <= '0;
        end else if (flush) begin
            r_slotV <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_slot[i]  <= w_reqIn[i];
                    r_slotV[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_slotV[i] <= 1'b0;
                end
            end
        end
    end

    // Flush leaves the round-robin position untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rrPtr <= '0;
        end else if (!flush) begin
            if (w_g1V)      r_rrPtr <= nextIdx(w_g1Idx);
            else if (w_g0V) r_rrPtr <= nextIdx(w_g0Idx);
        end
    end

    // Idle ports carry an all-zero record, so wb_rf_we is implicitly gated by wb_valid.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wbValid   <= '0;
            r_wbPort[0] <= '0;
            r_wbPort[1] <= '0;
        end else begin
            r_wbValid   <= {w_g1V, w_g0V};
            r_wbPort[0] <= w_g0V ? r_slot[w_g0Idx] : '0;
            r_wbPort[1] <= w_g1V ? r_slot[w_g1Idx] : '0;
        end
    end

    assign bus.wb_valid = r_wbValid;
    for (genvar k = 0; k < 2; k++) begin : g_pack
        assign bus.wb_rob_idx[k*ROB_W +: ROB_W]    = r_wbPort[k].rob_idx;
        assign bus.wb_phy_dest[k*PREG_W +: PREG_W] = r_wbPort[k].phy_dest;
        assign bus.wb_rf_we[k]                     = r_wbPort[k].rf_we;
        assign bus.wb_result[k*DATA_W +: DATA_W]   = r_wbPort[k].result;
        assign bus.wb_ex[k]                        = r_wbPort[k].ex;
        assign bus.wb_excode[k*EXC_W +: EXC_W]     = r_wbPort[k].excode;
    end

endmodule
